hazard_scoreboard: RTL

- Producer-side companion to the pipeline forwarding selector. Tracks every in-flight register writer in the E/M/W stages and owns the HI/LO multiply/divide busy window.
- Decides, per cycle, whether the instruction in D must stall, and publishes each stage's destination plus a "result ready to forward" flag.
- Sits between the D-stage decoder and the F/D pipeline-register enables.

---
 rtl/hazard_scoreboard.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
//
// Producer-side companion to the forwarding selector. It tracks the register
// writers in the E, M and W stages, owns the HI/LO multiply/divide busy
// window, and decides each cycle whether the instruction in D must stall.
//
// Parameters:
//   MULT_CYCLES  busy cycles after a mult/multu leaves E
//   DIV_CYCLES   busy cycles after a div/divu leaves E
//   CNT_W        md counter width, 2^CNT_W-1 >= max(MULT_CYCLES, DIV_CYCLES)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   d_valid      D holds a real instruction (0 = bubble)
//   d_rs, d_rt   source register addresses of the D instruction
//   d_tuse_rs/rt cycles until the source is consumed (0..2), 3 = unused
//   d_dst        destination register, 0 = no write
//   d_tnew       cycles after entering E until the result exists (0..2)
//   d_md_start   mult/multu/div/divu
//   d_md_is_div  with d_md_start: divide
//   d_md_use     mfhi/mflo/mthi/mtlo
//   stall        freeze F/D and inject a bubble into E
//   e/m/w_dst    destination held by each stage
//   e/m_ready    stage result is available for forwarding
//   md_busy      HI/LO unit busy
// ----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_dst,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_is_div,
    input  logic       d_md_use,
    output logic       stall,
    output logic [4:0] e_dst,
    output logic [4:0] m_dst,
    output logic [4:0] w_dst,
    output logic       e_ready,
    output logic       m_ready,
    output logic       md_busy
);

    localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES);

    // Stage records. W only needs its destination: its tnew is always 0.
    logic [4:0]       e_dst_q, e_dst_d;
    logic [1:0]       e_tnew_q, e_tnew_d;
    logic             e_md_q, e_md_d;
    logic             e_div_q, e_div_d;
    logic [4:0]       m_dst_q, m_dst_d;
    logic [1:0]       m_tnew_q, m_tnew_d;
    logic [4:0]       w_dst_q, w_dst_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic rs_hazard;
    logic rt_hazard;
    logic reg_stall;
    logic md_stall;
    logic md_busy_int;

    // E is the newest writer, so a match there hides any older match in M.
    // W is never consulted: its value is always forwardable.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] ex_dst,
        input logic [1:0] ex_tnew,
        input logic [4:0] mem_dst,
        input logic [1:0] mem_tnew
    );
        logic hz;
        hz = 1'b0;
        if ((tuse != 2'd3) && (src != 5'd0)) begin
            if (src == ex_dst) begin
                hz = (ex_tnew > tuse);
            end else if (src == mem_dst) begin
                hz = (mem_tnew > tuse);
            end
        end
        return hz;
    endfunction

    // ------------------------------------------------------------------
    // Stall decision (purely combinational, same cycle)
    // ------------------------------------------------------------------
    always_comb begin
        rs_hazard   = src_hazard(d_rs, d_tuse_rs, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
        rt_hazard   = src_hazard(d_rt, d_tuse_rt, e_dst_q, e_tnew_q, m_dst_q, m_tnew_q);
        reg_stall   = d_valid & (rs_hazard | rt_hazard);
        // An md op sitting in E has not loaded the counter yet but already
        // owns HI/LO.
        md_busy_int = (md_cnt_q != '0) | e_md_q;
        md_stall    = d_valid & (d_md_start | d_md_use) & md_busy_int;
        stall       = reg_stall | md_stall;
    end

    // ------------------------------------------------------------------
    // Next-state: records advance every cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_dst_d  = m_dst_q;
        m_dst_d  = e_dst_q;
        m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : (e_tnew_q - 2'd1);

        if (stall || !d_valid) begin
            e_dst_d  = 5'd0;
            e_tnew_d = 2'd0;
            e_md_d   = 1'b0;
            e_div_d  = 1'b0;
        end else begin
            e_dst_d  = d_dst;
            e_tnew_d = d_tnew;
            e_md_d   = d_md_start;
            e_div_d  = d_md_start & d_md_is_div;
        end

        // Load wins over decrement.
        if (e_md_q) begin
            md_cnt_d = e_div_q ? DivLoad : MultLoad;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end else begin
            md_cnt_d = md_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_dst_q  <= 5'd0;
            e_tnew_q <= 2'd0;
            e_md_q   <= 1'b0;
            e_div_q  <= 1'b0;
            m_dst_q  <= 5'd0;
            m_tnew_q <= 2'd0;
            w_dst_q  <= 5'd0;
            md_cnt_q <= '0;
        end else begin
            e_dst_q  <= e_dst_d;
            e_tnew_q <= e_tnew_d;
            e_md_q   <= e_md_d;
            e_div_q  <= e_div_d;
            m_dst_q  <= m_dst_d;
            m_tnew_q <= m_tnew_d;
            w_dst_q  <= w_dst_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // A $0 writer never advertises a ready result.
    always_comb begin
        e_dst   = e_dst_q;
        m_dst   = m_dst_q;
        w_dst   = w_dst_q;
        e_ready = (e_tnew_q == 2'd0) && (e_dst_q != 5'd0);
        m_ready = (m_tnew_q == 2'd0) && (m_dst_q != 5'd0);
        md_busy = md_busy_int;
    end

endmodule
